// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg
// Definitions shared by the fetch stage and the control unit of the
// multi-cycle MIPS CPU:
//   - PcSrc next-PC select encodings
//   - fetch FSM state type
//   - opcode constants decoded from IR[31:26] by the control unit
//   - small helpers for immediate / jump-target formation
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

  // Next-PC select driven by the control unit
  localparam logic [1:0] PCSRC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PCSRC_BR  = 2'b01;  // pc + 4 + (sext(imm16) << 2)
  localparam logic [1:0] PCSRC_JR  = 2'b10;  // register target
  localparam logic [1:0] PCSRC_J   = 2'b11;  // j / jal pseudo-direct target

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_READY = 2'd1,
    ST_RETRY = 2'd2
  } fetch_state_t;

  // Opcodes seen by the control unit on IR[31:26]
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Branch displacement in bytes: sign-extended word offset shifted by 2
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Pseudo-direct jump target: upper nibble of the sequential PC
  function automatic logic [31:0] jump_target(input logic [31:0] seq_pc,
                                              input logic [25:0] index);
    return {seq_pc[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection.
// Ports:
//   pc       in  32  current PC
//   instr    in  32  IR contents (branch immediate / jump index source)
//   jr_addr  in  32  rs data, jr target
//   PcSrc    in   2  select: 00 seq, 01 branch, 10 jr, 11 j/jal
//   next_pc  out 32  selected next PC (wraps modulo 2^32)
//   misalign out  1  jr selected with a target not word aligned
// ---------------------------------------------------------------------------
module next_pc_calc
  import cpu_defs_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] jr_addr,
  input  logic [1:0]  PcSrc,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] seq_pc;
  logic        unused_opcode;

  assign seq_pc        = pc + 32'd4;
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc  = seq_pc;
    misalign = 1'b0;
    case (PcSrc)
      PCSRC_SEQ: next_pc = seq_pc;
      PCSRC_BR:  next_pc = seq_pc + branch_offset(instr[15:0]);
      PCSRC_JR: begin
        // Low bits are dropped so the PC stays aligned; the fault is flagged.
        next_pc  = {jr_addr[31:2], 2'b00};
        misalign = |jr_addr[1:0];
      end
      PCSRC_J:   next_pc = jump_target(seq_pc, instr[25:0]);
      default:   next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of the multi-cycle MIPS CPU. Holds PC and IR, fetches from
// instruction memory over a req/ack handshake with timeout/retry, and
// advances the PC under control-unit PCWre/PcSrc.
// Ports:
//   clk, rst               clock (rising edge); async active-low reset
//   PCWre, IRWre           PC / IR write enables, honoured only in READY
//   PcSrc, jr_addr         next-PC select and jr target
//   imem_req/addr/ack/rdata  instruction memory handshake
//   pc, pc_plus4, instr    current PC, PC+4 (jal link), IR
//   fetch_busy             fetch in progress; control unit must stall
//   misalign_err           sticky: misaligned jr target taken
//   imem_timeout           sticky: a fetch ran out of wait cycles
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWre,
  input  logic [1:0]  PcSrc,
  input  logic        IRWre,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        fetch_busy,
  output logic        misalign_err,
  output logic        imem_timeout
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_t     state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      buffer;
  logic [31:0]      next_pc;
  logic             jr_misalign;
  logic             in_fetch, in_ready, timeout_hit;

  assign in_fetch    = (state == ST_FETCH);
  assign in_ready    = (state == ST_READY);
  assign timeout_hit = in_fetch && !imem_ack && (wait_cnt == WAIT_LAST);
  assign pc_plus4    = pc + 32'd4;

  next_pc_calc u_next_pc (
    .pc       (pc),
    .instr    (instr),
    .jr_addr  (jr_addr),
    .PcSrc    (PcSrc),
    .next_pc  (next_pc),
    .misalign (jr_misalign)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FETCH;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (imem_ack)         state_next = ST_READY;
        else if (timeout_hit) state_next = ST_RETRY;
      end
      ST_RETRY: state_next = ST_FETCH;
      ST_READY: if (PCWre) state_next = ST_FETCH;
      default:  state_next = ST_FETCH;
    endcase
  end

  // Outputs; the request is gated by reset so an aborted fetch drops at once
  always_comb begin
    imem_req   = rst && in_fetch;
    imem_addr  = pc;
    fetch_busy = !in_ready;
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      instr        <= '0;
      buffer       <= '0;
      wait_cnt     <= '0;
      misalign_err <= 1'b0;
      imem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            buffer   <= imem_rdata;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            imem_timeout <= 1'b1;
            wait_cnt     <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_READY: begin
          // IR takes the current buffer and the PC uses the current IR,
          // so a simultaneous IRWre/PCWre applies both from old values.
          if (IRWre) instr <= buffer;
          if (PCWre) begin
            pc <= next_pc;
            if (jr_misalign) misalign_err <= 1'b1;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWre, IRWre, imem_ack;
  logic [1:0]  PcSrc;
  logic [31:0] jr_addr, imem_rdata;
  logic        imem_req, fetch_busy, misalign_err, imem_timeout;
  logic [31:0] imem_addr, pc, pc_plus4, instr;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state, derived from the architectural rules
  logic [31:0] exp_pc, exp_instr, exp_buf;
  logic        exp_mis, exp_to;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .PCWre(PCWre), .PcSrc(PcSrc), .IRWre(IRWre),
    .jr_addr(jr_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
    .pc_plus4(pc_plus4), .instr(instr), .fetch_busy(fetch_busy),
    .misalign_err(misalign_err), .imem_timeout(imem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_next_pc(input logic [31:0] cur_pc,
      input logic [31:0] ir, input logic [1:0] src, input logic [31:0] jr);
    logic [31:0] imm;
    case (src)
      2'd0: return cur_pc + 32'd4;
      2'd1: begin
        imm = ir & 32'h0000_FFFF;
        if (imm >= 32'h0000_8000) imm = imm + 32'hFFFF_0000;
        return cur_pc + 32'd4 + imm * 32'd4;
      end
      2'd2: return jr - (jr % 32'd4);
      default: return ((cur_pc + 32'd4) & 32'hF000_0000) + (ir & 32'h03FF_FFFF) * 32'd4;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  // One cycle of control-unit activity while READY
  task automatic ready_op(input logic ir, input logic pw, input logic [1:0] src,
                          input logic [31:0] jr);
    logic [31:0] np;
    IRWre = ir; PCWre = pw; PcSrc = src; jr_addr = jr;
    step();
    IRWre = 1'b0; PCWre = 1'b0;
    np = model_next_pc(exp_pc, exp_instr, src, jr);
    if (ir) exp_instr = exp_buf;
    if (pw) begin
      exp_pc = np;
      if (src == 2'd2 && (jr % 32'd4) != 0) exp_mis = 1'b1;
    end
  endtask

  // Memory side: ack after 'delay' request cycles without ack
  task automatic fetch(input logic [31:0] data, input int unsigned delay,
                       output int unsigned bad, output bit done);
    int unsigned left;
    left = delay; bad = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (imem_req === 1'b1) begin
        if (imem_addr !== exp_pc) bad++;
        if (left == 0) begin imem_ack = 1'b1; imem_rdata = data; end
        else left--;
      end
      step();
      if (imem_ack) begin imem_ack = 1'b0; done = 1'b1; end
    end
    if (done) exp_buf = data;
    if (delay >= MAX_WAIT) exp_to = 1'b1;
  endtask

  // From READY: jump to target, fetch data, load it into IR
  task automatic land(input logic [31:0] target, input logic [31:0] data,
                      output bit ok);
    int unsigned bad; bit done;
    ready_op(1'b0, 1'b1, 2'd2, target);
    fetch(data, 0, bad, done);
    ready_op(1'b1, 1'b0, 2'd0, 32'h0);
    ok = done && (bad == 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; PCWre = 0; IRWre = 0; PcSrc = 0; jr_addr = 0;
    imem_ack = 0; imem_rdata = 0;
    step(); step();
    checks++;
    if (imem_req !== 1'b0 || pc !== RESET_PC || instr !== 32'h0 ||
        misalign_err !== 1'b0 || imem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b pc=%h instr=%h mis=%b to=%b, required 0 %h 0 0 0",
               imem_req, pc, instr, misalign_err, imem_timeout, RESET_PC);
    end
    rst = 1'b1;
    exp_pc = RESET_PC; exp_instr = 0; exp_buf = 0; exp_mis = 0; exp_to = 0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h busy=%b, required 1 %h 1",
               imem_req, imem_addr, fetch_busy, RESET_PC);
    end
    @(negedge clk);
  endtask

  task automatic test_first_fetch();
    int unsigned bad; bit done;
    fetch(32'h0800_0004, 0, bad, done);
    checks++;
    if (!done || bad != 0 || fetch_busy !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: done=%b badaddr=%0d busy=%b req=%b, required 1 0 0 0",
               done, bad, fetch_busy, imem_req);
    end
    ready_op(1'b1, 1'b0, 2'd0, 32'h0);
    checks++;
    if (instr !== 32'h0800_0004) begin
      errors++; $display("FAIL first_ir_load: instr=%h, required 08000004", instr);
    end
    ready_op(1'b0, 1'b1, 2'd0, 32'h0);
    checks++;
    if (pc !== 32'h4 || fetch_busy !== 1'b1 || pc_plus4 !== 32'h8) begin
      errors++;
      $display("FAIL seq_pc: pc=%h busy=%b plus4=%h, required 4 1 8", pc, fetch_busy, pc_plus4);
    end
  endtask

  task automatic test_branch();
    int unsigned bad; bit done, ok;
    fetch(32'h0, 0, bad, done);
    land(32'h10, 32'hD000_FFFE, ok);
    ready_op(1'b0, 1'b1, 2'd1, 32'h0);
    checks++;
    if (!ok || pc !== 32'h0000_000C) begin
      errors++; $display("FAIL branch_back: pc=%h ok=%b, required 0000000c 1", pc, ok);
    end
    fetch(32'h0, 0, bad, done);
    land(32'h10, 32'hD000_0003, ok);
    ready_op(1'b0, 1'b1, 2'd1, 32'h0);
    checks++;
    if (!ok || pc !== 32'h0000_0020) begin
      errors++; $display("FAIL branch_fwd: pc=%h ok=%b, required 00000020 1", pc, ok);
    end
  endtask

  task automatic test_jump();
    int unsigned bad; bit done, ok;
    fetch(32'h0, 0, bad, done);
    land(32'hF000_0000, 32'h0800_0040, ok);
    ready_op(1'b0, 1'b1, 2'd3, 32'h0);
    checks++;
    if (!ok || pc !== 32'hF000_0100 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL jump: pc=%h mis=%b ok=%b, required f0000100 0 1", pc, misalign_err, ok);
    end
    fetch(32'h0, 0, bad, done);
    ready_op(1'b0, 1'b1, 2'd2, 32'h0000_0103);
    checks++;
    if (pc !== 32'h0000_0100 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL jr_misalign: pc=%h mis=%b, required 00000100 1", pc, misalign_err);
    end
  endtask

  task automatic test_timeout();
    int unsigned bad_cycles; int unsigned bad; bit done;
    bad_cycles = 0;
    for (int i = 0; i < int'(MAX_WAIT); i++) begin
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) bad_cycles++;
      if (i == int'(MAX_WAIT) - 1) begin
        checks++;
        if (imem_timeout !== 1'b0) begin
          errors++; $display("FAIL timeout_early: to=%b, required 0", imem_timeout);
        end
      end
      step();
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++; $display("FAIL timeout_wait: bad cycles=%0d, required 0", bad_cycles);
    end
    exp_to = 1'b1;
    checks++;
    if (imem_req !== 1'b0 || imem_timeout !== 1'b1 || fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_retry: req=%b to=%b busy=%b, required 0 1 1",
               imem_req, imem_timeout, fetch_busy);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL timeout_refetch: req=%b addr=%h, required 1 00000100", imem_req, imem_addr);
    end
    fetch(32'h2000_0001, 0, bad, done);
    checks++;
    if (!done || bad != 0 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL retry_ack: done=%b bad=%0d busy=%b, required 1 0 0", done, bad, fetch_busy);
    end
  endtask

  task automatic test_ignored();
    int unsigned bad; bit done;
    ready_op(1'b0, 1'b1, 2'd0, 32'h0);
    PCWre = 1'b1; IRWre = 1'b1; PcSrc = 2'd2; jr_addr = 32'h0000_0554;
    step();
    PCWre = 1'b0; IRWre = 1'b0;
    checks++;
    if (pc !== exp_pc || instr !== exp_instr) begin
      errors++;
      $display("FAIL ignore_in_fetch: pc=%h instr=%h, required %h %h", pc, instr, exp_pc, exp_instr);
    end
    fetch(32'h1111_2222, 0, bad, done);
    imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
    step();
    imem_ack = 1'b0;
    ready_op(1'b1, 1'b0, 2'd0, 32'h0);
    checks++;
    if (!done || instr !== 32'h1111_2222 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_in_ready: instr=%h busy=%b, required 11112222 0", instr, fetch_busy);
    end
    // Simultaneous IRWre and PCWre: IR takes buffer, branch uses the old IR
    ready_op(1'b1, 1'b1, 2'd1, 32'h0);
    checks++;
    if (pc !== exp_pc || instr !== exp_instr) begin
      errors++;
      $display("FAIL both_enables: pc=%h instr=%h, required %h %h", pc, instr, exp_pc, exp_instr);
    end
  endtask

  task automatic test_random();
    int unsigned bad, nbad, delay; bit done;
    logic [31:0] data, jr;
    logic [1:0] src;
    nbad = 0;
    // Enter READY from the FETCH left by the previous test
    fetch($urandom, 0, bad, done);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) ready_op(1'b1, 1'b0, 2'd0, 32'h0);
      src = 2'($urandom_range(0, 3));
      jr = $urandom;
      ready_op(1'($urandom_range(0, 1)), 1'b1, src, jr);
      checks++;
      if (pc !== exp_pc || instr !== exp_instr) begin
        errors++;
        $display("FAIL rand_pc[%0d]: pc=%h instr=%h, required %h %h",
                 i, pc, instr, exp_pc, exp_instr);
      end
      data = $urandom;
      delay = ($urandom_range(0, 7) == 0) ? MAX_WAIT + 1 : $urandom_range(0, 3);
      fetch(data, delay, bad, done);
      if (!done || bad != 0) nbad++;
      checks++;
      if (misalign_err !== exp_mis || imem_timeout !== exp_to || fetch_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_flags[%0d]: mis=%b to=%b busy=%b, required %b %b 0",
                 i, misalign_err, imem_timeout, fetch_busy, exp_mis, exp_to);
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++; $display("FAIL rand_fetch: bad fetches=%0d, required 0", nbad);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int unsigned bad; bit done;
    ready_op(1'b0, 1'b1, 2'd0, 32'h0);
    step(); step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== RESET_PC || instr !== 32'h0 ||
        misalign_err !== 1'b0 || imem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: req=%b pc=%h instr=%h mis=%b to=%b, required 0 %h 0 0 0",
               imem_req, pc, instr, misalign_err, imem_timeout, RESET_PC);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    rst = 1'b1;
    exp_pc = RESET_PC; exp_instr = 0; exp_buf = 0; exp_mis = 0; exp_to = 0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || fetch_busy !== 1'b1 || instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_restart: req=%b addr=%h busy=%b instr=%h, required 1 %h 1 0",
               imem_req, imem_addr, fetch_busy, instr, RESET_PC);
    end
    @(negedge clk);
    fetch(32'h1234_5678, 0, bad, done);
    ready_op(1'b1, 1'b0, 2'd0, 32'h0);
    checks++;
    if (!done || bad != 0 || instr !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_refetch: done=%b bad=%0d instr=%h, required 1 0 12345678",
               done, bad, instr);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_timeout();
    test_ignored();
    test_random();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the multi-cycle MIPS CPU, sitting directly upstream of the control unit. It holds the PC and the instruction register (IR), and computes the next PC from the control unit's PcSrc selection. It fetches from instruction memory over a req/ack handshake. IR[31:26] drives the control unit's op input, and PCWre and IRWre from the control unit gate the PC and IR updates.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; must be word aligned.
MAX_WAIT, 8, number of cycles in FETCH without imem_ack before a timeout and retry.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low.
PCWre  in  1  PC write enable from the control unit.
PcSrc  in  2  next-PC select: 00 pc+4, 01 branch, 10 jr, 11 j/jal.
IRWre  in  1  IR load enable from the control unit.
jr_addr  in  32  rs register data, used as the jr target.
imem_req  out  1  fetch request, held until ack.
imem_addr  out  32  fetch address; equals pc while imem_req is high.
imem_ack  in  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
imem_rdata  in  32  fetched instruction word.
pc  out  32  current PC.
pc_plus4  out  32  pc+4, combinational; used as the jal link value.
instr  out  32  IR contents.
fetch_busy  out  1  high in FETCH and RETRY; the control unit must hold its state while this is high.
misalign_err  out  1  sticky; set by a misaligned jr target.
imem_timeout  out  1  sticky; set by any fetch timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, instr=0, internal buffer=0.
  - imem_req=0, misalign_err=0, imem_timeout=0, wait counter=0.
  - state=FETCH, but imem_req is forced to 0 while rst=0.
- Reset mid-fetch aborts the fetch immediately: imem_req drops combinationally, and a late ack is ignored.
- FSM states: FETCH, READY, RETRY.
  - FETCH: imem_req=1, imem_addr=pc, counter increments each cycle.
    - If imem_ack: buffer<=imem_rdata, counter<=0, go to READY.
    - Else if counter==MAX_WAIT-1: imem_timeout<=1, counter<=0, go to RETRY.
  - RETRY: imem_req=0 for exactly one cycle, then return to FETCH with the same pc.
  - READY: imem_req=0.
    - If IRWre: instr<=buffer.
    - If PCWre: pc<=next_pc, go to FETCH.
    - If both are asserted in the same cycle, the IR loads the old buffer and the PC advances; both happen.
- PCWre and IRWre are ignored in FETCH and RETRY. The control unit is required not to issue them; the bench checks that they are ignored.
- imem_ack is ignored outside FETCH.
- Next-PC computation (32-bit, wrap modulo 2^32, no overflow flag):
  - 00: pc+4.
  - 01: pc+4 + (sign_extend(instr[15:0]) << 2).
  - 10: {jr_addr[31:2],2'b00}; if jr_addr[1:0]!=0, set misalign_err.
  - 11: {pc_plus4[31:28], instr[25:0], 2'b00}.
- Branch and jump fields are taken from the IR (instr), not from the buffer.
- fetch_busy = (state!=READY) while rst=1.
- Latency: a fetch completes with READY on the edge of the ack cycle. The minimum fetch is 1 cycle with ack in the first FETCH cycle.

Decomposition:
- Shared package cpu_defs_pkg:
  - PcSrc encodings PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11.
  - FSM state encodings.
  - Opcode constants shared with the control unit.
- One sub-module, next_pc_calc: purely combinational; inputs pc, instr, jr_addr, PcSrc; outputs next_pc and misalign.

Test Plan:
- Reset, then ack on the first FETCH cycle with rdata=32'h0800_0004 → imem_addr=0, READY next cycle. IRWre → instr=32'h0800_0004. PCWre with PcSrc=00 → pc=4.
- pc=32'h0000_0010, instr=32'hD000_FFFE, PcSrc=01, PCWre → pc=32'h0000_000C. With imm 16'h0003 instead → pc=32'h0000_0020.
- pc=32'hF000_0000, instr[25:0]=26'h000_0040, PcSrc=11 → pc=32'hF000_0100. PcSrc=10 with jr_addr=32'h0000_0103 → pc=32'h0000_0100 and misalign_err=1, remaining set until reset.
- No ack for 8 cycles (MAX_WAIT=8) → imem_timeout=1, imem_req low for 1 cycle, then re-asserted with the same imem_addr. Ack on the retry → READY.
- PCWre and IRWre pulsed during FETCH → pc and instr unchanged. Ack pulsed in READY → buffer unchanged.
- rst pulled low mid-FETCH → imem_req=0 immediately, pc=RESET_PC. A late ack during reset has no effect. After release, fetch restarts at RESET_PC.
